multdiv_step_sequencer: RTL and testbench

Parametrised, clocked step sequencer for the multi-cycle multiplier/divider datapath. On `start` it walks a step index from 0 to STEPS-1, one step per un-stalled cycle, and presents the index both binary-encoded and decoded to a one-hot step-select vector. It replaces the fixed 3-to-8 step decode with a generic N-way decode plus start/busy/done handshake, stall and abort. It sits between the multdiv control FSM and the per-step datapath enables.

---
 rtl/multdiv_pkg.sv | 15 +
 rtl/multdiv_step_sequencer_onehot_decoder.sv | 22 ++
 rtl/multdiv_step_sequencer.sv | 92 +++++++++
 tb/tb_multdiv_step_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the multi-cycle multiplier/divider control path.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Index width for an N-way step counter; a single step still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multdiv_step_sequencer_onehot_decoder.sv
// Generic binary-to-one-hot decoder with an enable that forces the output to zero.
module onehot_decoder
    import multdiv_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = idx_width(N)
) (
    input  logic [IW-1:0] idx,
    input  logic          en,
    output logic [N-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                onehot[i] = (idx == IW'(i));
            end
        end
    end

endmodule

// File: rtl/multdiv_step_sequencer.sv
// Step sequencer for the multdiv datapath: walks a step index 0..STEPS-1 with
// start/busy/done handshake, stall and abort; all outputs decode registered state.
module multdiv_step_sequencer
    import multdiv_pkg::*;
#(
    parameter int STEPS = 32,
    parameter int IW    = idx_width(STEPS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic [IW-1:0]    step_idx,
    output logic [STEPS-1:0] step_onehot,
    output logic             first,
    output logic             last,
    output logic             done
);

    localparam logic [IW-1:0] LAST_IDX = IW'(STEPS - 1);

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [IW-1:0] idx_nxt;
    logic          at_last;

    assign at_last = (step_idx == LAST_IDX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            step_idx <= '0;
        end else begin
            state    <= state_nxt;
            step_idx <= idx_nxt;
        end
    end

    // Abort wins over stall and advance; the index is forced to zero whenever RUN is left.
    always_comb begin
        state_nxt = state;
        idx_nxt   = step_idx;
        unique case (state)
            IDLE: begin
                idx_nxt = '0;
                if (start && !abort) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else if (!stall) begin
                    if (at_last) begin
                        state_nxt = DONE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = step_idx + IW'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign first = busy && (step_idx == '0);
    assign last  = busy && at_last;

    onehot_decoder #(
        .N  (STEPS),
        .IW (IW)
    ) u_decoder (
        .idx    (step_idx),
        .en     (busy),
        .onehot (step_onehot)
    );

endmodule

// File: tb/tb_multdiv_step_sequencer.sv
// Scoreboard bench for multdiv_step_sequencer at STEPS = 8, 32, 1 and 5.
module tb_multdiv_step_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0] start = '0;
    logic [3:0] stall = '0;
    logic [3:0] abort = '0;
    logic [3:0] ready, busy, done, first, last;
    logic [3:0][7:0]  idx_w;
    logic [3:0][31:0] oh_w;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int S = (g == 0) ? 8 : (g == 1) ? 32 : (g == 2) ? 1 : 5;
        localparam int W = (S > 1) ? $clog2(S) : 1;
        logic [W-1:0] idx;
        logic [S-1:0] oh;
        multdiv_step_sequencer #(.STEPS(S)) u_dut (
            .clock       (clock),
            .reset       (reset),
            .start       (start[g]),
            .stall       (stall[g]),
            .abort       (abort[g]),
            .ready       (ready[g]),
            .busy        (busy[g]),
            .step_idx    (idx),
            .step_onehot (oh),
            .first       (first[g]),
            .last        (last[g]),
            .done        (done[g])
        );
        assign idx_w[g] = 8'(idx);
        assign oh_w[g]  = 32'(oh);
    end

    typedef struct {
        int dut;
        int cyc;
        int idx;
        bit is_done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_done_cyc = -1;
    int   stall_a = 0;
    int   stall_b = 0;
    int   stall_len = 0;

    function automatic int steps_of(input int d);
        case (d)
            0:       return 8;
            1:       return 32;
            2:       return 1;
            default: return 5;
        endcase
    endfunction

    function automatic bit in_stall(input int rel);
        return ((rel >= stall_a) && (rel < stall_a + stall_len)) ||
               ((rel >= stall_b) && (rel < stall_b + stall_len));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every cycle a DUT shows busy or done, pop the next expected entry and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            for (int d = 0; d < 4; d++) begin
                if (busy[d] === 1'b1 || done[d] === 1'b1) begin
                    if (done[d] === 1'b1) last_done_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'({busy[d], done[d]}), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("dut_id",   64'(d),         64'(e.dut));
                        check("cycle",    64'(cyc),       64'(e.cyc));
                        check("step_idx", 64'(idx_w[d]),  64'(e.idx));
                        check("onehot",   64'(oh_w[d]),   e.is_done ? 64'(0) : (64'(1) << e.idx));
                        check("first",    64'(first[d]),  64'(!e.is_done && e.idx == 0));
                        check("last",     64'(last[d]),   64'(!e.is_done && e.idx == steps_of(d) - 1));
                        check("done",     64'(done[d]),   64'(e.is_done));
                        check("busy",     64'(busy[d]),   64'(!e.is_done));
                        check("ready",    64'(ready[d]),  64'(0));
                    end
                end
            end
        end
    end

    // Reference walk of one operation; returns the relative cycle at which ready returns.
    task automatic push_run(input int d, input int n, input int abort_rel, input int reset_rel,
                            output int end_rel);
        int c;
        int idx;
        int s;
        c   = n + 1;
        idx = 0;
        s   = steps_of(d);
        forever begin
            exp_q.push_back('{d, c, idx, 1'b0});
            if (c - n == abort_rel || c - n == reset_rel) begin
                end_rel = c - n + 1;
                return;
            end
            if (!in_stall(c - n)) begin
                if (idx == s - 1) break;
                idx++;
            end
            c++;
        end
        exp_q.push_back('{d, c + 1, 0, 1'b1});
        end_rel = c + 1 - n + 1;
    endtask

    task automatic apply_stimulus(input int d, input int abort_rel, input int reset_rel,
                                  input int hold_start, output int n);
        int end_rel;
        int rel;
        n = cyc;
        last_done_cyc = -1;
        start[d] = 1'b1;
        push_run(d, n, abort_rel, reset_rel, end_rel);
        rel = 0;
        while (rel < end_rel) begin
            @(negedge clock);
            rel = cyc - n;
            start[d] = (rel <= hold_start) && (rel < end_rel);
            stall[d] = in_stall(rel) && (rel < end_rel);
            abort[d] = (rel == abort_rel);
            reset    = (rel == reset_rel);
        end
        start[d] = 1'b0;
        stall[d] = 1'b0;
        abort[d] = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic check_output(input string tag, input int d);
        check({tag, "_ready"},  64'(ready[d]), 64'(1));
        check({tag, "_busy"},   64'(busy[d]),  64'(0));
        check({tag, "_done"},   64'(done[d]),  64'(0));
        check({tag, "_first"},  64'(first[d]), 64'(0));
        check({tag, "_last"},   64'(last[d]),  64'(0));
        check({tag, "_idx"},    64'(idx_w[d]), 64'(0));
        check({tag, "_onehot"}, 64'(oh_w[d]),  64'(0));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        for (int d = 0; d < 4; d++) check_output("reset_state", d);
        reset = 1'b0;
        @(negedge clock);

        // STEPS=8 plain run: done 9 cycles after the start cycle, ready at 10.
        apply_stimulus(0, -1, -1, 0, n);
        check("s8_done_latency", 64'(last_done_cyc - n), 64'(9));
        check("s8_ready_latency", 64'(cyc - n), 64'(10));
        check_output("s8_after", 0);
        check("s8_drained", 64'(exp_q.size()), 64'(0));

        // STEPS=32 with stalls at steps 5 and 6, three cycles each.
        stall_a = 6;
        stall_b = 10;
        stall_len = 3;
        apply_stimulus(1, -1, -1, 0, n);
        check("s32_stall_done_latency", 64'(last_done_cyc - n), 64'(39));
        check_output("s32_after", 1);
        stall_len = 0;

        // STEPS=8 abort while at step 4, then an immediate restart.
        apply_stimulus(0, 5, -1, 0, n);
        check("abort_no_done", 64'(last_done_cyc), 64'(-1));
        check_output("abort_after", 0);
        apply_stimulus(0, -1, -1, 0, n);
        check("restart_done_latency", 64'(last_done_cyc - n), 64'(9));

        // start held through RUN and DONE must not retrigger.
        apply_stimulus(0, -1, -1, 9, n);
        check_output("start_held_after", 0);
        repeat (3) @(negedge clock);
        check_output("start_held_idle", 0);

        // start together with abort in IDLE stays IDLE.
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check_output("start_abort_idle", 0);

        // Synchronous reset while at step 3.
        apply_stimulus(0, -1, 4, 0, n);
        check("reset_no_done", 64'(last_done_cyc), 64'(-1));
        check_output("reset_mid", 0);

        // STEPS=1: one RUN cycle with first and last both set.
        apply_stimulus(2, -1, -1, 0, n);
        check("s1_done_latency", 64'(last_done_cyc - n), 64'(2));
        check_output("s1_after", 2);

        // STEPS=5 with stall asserted in DONE and abort asserted in DONE: both ignored.
        stall_a = 6;
        stall_b = 6;
        stall_len = 1;
        apply_stimulus(3, 6, -1, 0, n);
        check("s5_done_latency", 64'(last_done_cyc - n), 64'(6));
        check_output("s5_after", 3);
        stall_len = 0;

        repeat (2) @(negedge clock);
        check("final_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] timeout");
    end

endmodule
